// File: rtl/maze_pkg.sv
// Shared constants for the maze cell store: geometry, cell codes and FSM state codes.
`timescale 1ns/1ps
package maze_pkg;

  localparam int MAZE_WIDTH = 6;

  localparam logic [1:0] CELL_FREE = 2'd0;
  localparam logic [1:0] CELL_WALL = 2'd1;
  localparam logic [1:0] CELL_PATH = 2'd2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

endpackage

// File: rtl/maze_cell_ram.sv
// 2-bit cell array with one shared address: combinational read, synchronous write.
`timescale 1ns/1ps
module maze_cell_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [1:0]        wr_data,
  output logic [1:0]        rd_data
);

  logic [1:0] mem [2**ADDR_W];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/maze_store.sv
// Maze cell store beside the wall-follower solver: serial map load, registered reads, visit marking.
// Define MAZE_STORE_CLEAR_EN to add the clear_path sweep that turns PATH cells back into FREE.
`timescale 1ns/1ps
module maze_store
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic                    load_data,
  output logic                    load_ready,
  output logic                    loaded,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  output logic                    maze_in,
  output logic [2*maze_width:0]   path_cnt,
  output logic                    err
`ifdef MAZE_STORE_CLEAR_EN
  ,
  input  logic                    clear_path,
  output logic                    clear_busy
`endif
);

  localparam int AW = 2 * maze_width;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              loaded_q, loaded_d;
  logic [AW:0]       path_cnt_q, path_cnt_d;
  logic              err_q, err_d;
  logic              maze_in_q, maze_in_d;

  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [1:0]        ram_wdata;
  logic [1:0]        ram_rdata;
  logic              solver_ok;

  maze_cell_ram #(.ADDR_W(AW)) u_ram (
    .clk     (clk),
    .addr    (ram_addr),
    .we      (ram_we),
    .wr_data (ram_wdata),
    .rd_data (ram_rdata)
  );

  assign solver_ok = (state_q == READY) && !load_start;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    loaded_d   = loaded_q;
    path_cnt_d = path_cnt_q;
    err_d      = err_q;
    maze_in_d  = maze_in_q;
    ram_we     = 1'b0;
    ram_wdata  = CELL_FREE;
    ram_addr   = {row, col};

    if (state_q == LOAD || state_q == CLEAR) ram_addr = idx_q;

    // Solver port: the read and the mark see the same old cell value (read-before-write).
    if (maze_oe || maze_we) begin
      if (!solver_ok) begin
        err_d     = 1'b1;
        maze_in_d = 1'b1;
      end else begin
        if (maze_oe) maze_in_d = (ram_rdata == CELL_WALL);
        if (maze_we) begin
          if (ram_rdata == CELL_FREE) begin
            ram_we    = 1'b1;
            ram_wdata = CELL_PATH;
            if (path_cnt_q != '1) path_cnt_d = path_cnt_q + 1'b1;
          end else if (ram_rdata == CELL_WALL) begin
            err_d = 1'b1;
          end
        end
      end
    end

    // load_start wins from every state and drops any load beat in the same cycle.
    if (load_start) begin
      state_d    = LOAD;
      idx_d      = '0;
      loaded_d   = 1'b0;
      path_cnt_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_valid) begin
            ram_we    = 1'b1;
            ram_wdata = load_data ? CELL_WALL : CELL_FREE;
            idx_d     = idx_q + 1'b1;
            if (idx_q == '1) begin
              state_d  = READY;
              loaded_d = 1'b1;
            end
          end
        end
`ifdef MAZE_STORE_CLEAR_EN
        READY: begin
          if (clear_path) begin
            state_d  = CLEAR;
            idx_d    = '0;
            loaded_d = 1'b0;
          end
        end
        CLEAR: begin
          if (ram_rdata == CELL_PATH) begin
            ram_we    = 1'b1;
            ram_wdata = CELL_FREE;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == '1) begin
            state_d    = READY;
            loaded_d   = 1'b1;
            path_cnt_d = '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      loaded_q   <= 1'b0;
      path_cnt_q <= '0;
      err_q      <= 1'b0;
      maze_in_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      loaded_q   <= loaded_d;
      path_cnt_q <= path_cnt_d;
      err_q      <= err_d;
      maze_in_q  <= maze_in_d;
    end
  end

  assign load_ready = (state_q == LOAD);
  assign loaded     = loaded_q;
  assign maze_in    = maze_in_q;
  assign path_cnt   = path_cnt_q;
  assign err        = err_q;
`ifdef MAZE_STORE_CLEAR_EN
  assign clear_busy = (state_q == CLEAR);
`endif

endmodule

// File: tb/tb_maze_store.sv
// Self-checking bench for maze_store against a cell-level reference model of the maze.
`timescale 1ns/1ps
module tb_maze_store;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_data = 1'b0;
  logic        load_ready;
  logic        loaded;
  logic [5:0]  row = '0;
  logic [5:0]  col = '0;
  logic        maze_oe = 1'b0;
  logic        maze_we = 1'b0;
  logic        maze_in;
  logic [12:0] path_cnt;
  logic        err;
`ifdef MAZE_STORE_CLEAR_EN
  logic        clear_path = 1'b0;
  logic        clear_busy;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 free, 1 wall, 2 visited
  int   model_cell [4096];
  bit   next_map [4096];
  int   exp_cnt = 0;
  logic exp_err = 1'b0;
  logic exp_in = 1'b1;
  logic pre_loaded;
  logic ready_seen;

  maze_store dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .loaded     (loaded),
    .row        (row),
    .col        (col),
    .maze_oe    (maze_oe),
    .maze_we    (maze_we),
    .maze_in    (maze_in),
    .path_cnt   (path_cnt),
    .err        (err)
`ifdef MAZE_STORE_CLEAR_EN
    ,
    .clear_path (clear_path),
    .clear_busy (clear_busy)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_op(input logic oe, input logic we, input int r, input int c, input bit legal);
    int a;
    a = r * 64 + c;
    if (!legal) begin
      exp_err = 1'b1;
      exp_in  = 1'b1;
    end else begin
      if (oe) exp_in = (model_cell[a] == 1);
      if (we) begin
        if (model_cell[a] == 0) begin
          model_cell[a] = 2;
          exp_cnt++;
        end else if (model_cell[a] == 1) begin
          exp_err = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic oe, input logic we, input int r, input int c, input bit legal);
    model_op(oe, we, r, c, legal);
    row = 6'(r);
    col = 6'(c);
    maze_oe = oe;
    maze_we = we;
    step();
    maze_oe = 1'b0;
    maze_we = 1'b0;
  endtask

  task automatic stream_map(input int abort_at);
    int i;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    ready_seen = load_ready;
    pre_loaded = 1'b1;
    i = 0;
    while (i < 4096 && i != abort_at) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = next_map[i];
      if (load_valid && i == 4095) pre_loaded = loaded;
      step();
      if (load_valid) i++;
    end
    load_valid = 1'b0;
    if (abort_at < 0 || abort_at >= 4096) begin
      for (int k = 0; k < 4096; k++) model_cell[k] = next_map[k] ? 1 : 0;
      exp_cnt = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    step();
    vectors++; if (maze_in !== 1'b1) begin miscompares++; $display("FAIL reset_maze_in: got %b expected 1", maze_in); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
    vectors++; if (path_cnt !== 13'd0) begin miscompares++; $display("FAIL reset_path_cnt: got %0d expected 0", path_cnt); end
    vectors++; if (loaded !== 1'b0 || load_ready !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got loaded=%b ready=%b expected 0/0", loaded, load_ready); end
    drive(1'b1, 1'b0, 5, 5, 1'b0);
    vectors++; if (maze_in !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL idle_oe: got maze_in=%b err=%b expected 1/1", maze_in, err); end
    vectors++; if (loaded !== 1'b0 || load_ready !== 1'b0) begin miscompares++; $display("FAIL idle_flags: got loaded=%b ready=%b expected 0/0", loaded, load_ready); end
  endtask

  task automatic test_load();
    int r, c;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    exp_err = 1'b0;
    exp_in  = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      r = k / 64;
      c = k % 64;
      next_map[k] = (r == 0 || r == 63 || c == 0 || c == 63) && !(r == 0 && c == 7);
    end
    stream_map(-1);
    vectors++; if (ready_seen !== 1'b1) begin miscompares++; $display("FAIL load_ready: got %b expected 1", ready_seen); end
    vectors++; if (pre_loaded !== 1'b0) begin miscompares++; $display("FAIL loaded_early: got %b expected 0", pre_loaded); end
    vectors++; if (loaded !== 1'b1 || load_ready !== 1'b0) begin miscompares++; $display("FAIL loaded_rise: got loaded=%b ready=%b expected 1/0", loaded, load_ready); end
    drive(1'b1, 1'b0, 0, 0, 1'b1);
    vectors++; if (maze_in !== 1'b1) begin miscompares++; $display("FAIL read_0_0: got %b expected 1", maze_in); end
    drive(1'b1, 1'b0, 0, 7, 1'b1);
    vectors++; if (maze_in !== 1'b0) begin miscompares++; $display("FAIL read_0_7: got %b expected 0", maze_in); end
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 63);
      c = $urandom_range(0, 63);
      drive(1'b1, 1'b0, r, c, 1'b1);
      vectors++; if (maze_in !== exp_in) begin miscompares++; $display("FAIL map_read(%0d,%0d): got %b expected %b", r, c, maze_in, exp_in); end
    end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL load_err: got %b expected 0", err); end
  endtask

  task automatic test_mark();
    drive(1'b0, 1'b1, 3, 3, 1'b1);
    drive(1'b0, 1'b1, 3, 3, 1'b1);
    drive(1'b0, 1'b1, 3, 4, 1'b1);
    vectors++; if (path_cnt !== 13'd2) begin miscompares++; $display("FAIL mark_count: got %0d expected 2", path_cnt); end
    drive(1'b1, 1'b0, 3, 3, 1'b1);
    vectors++; if (maze_in !== 1'b0) begin miscompares++; $display("FAIL read_marked: got %b expected 0", maze_in); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_before_wall: got %b expected 0", err); end
    drive(1'b0, 1'b1, 0, 0, 1'b1);
    vectors++; if (err !== 1'b1 || path_cnt !== 13'd2) begin miscompares++; $display("FAIL mark_wall: got err=%b cnt=%0d expected 1/2", err, path_cnt); end
  endtask

  task automatic test_oe_we_same();
    drive(1'b1, 1'b0, 0, 0, 1'b1);
    drive(1'b1, 1'b1, 10, 10, 1'b1);
    vectors++; if (maze_in !== 1'b0 || path_cnt !== 13'(exp_cnt)) begin miscompares++; $display("FAIL rmw_free: got in=%b cnt=%0d expected 0/%0d", maze_in, path_cnt, exp_cnt); end
    drive(1'b1, 1'b1, 63, 0, 1'b1);
    vectors++; if (maze_in !== 1'b1 || err !== 1'b1 || path_cnt !== 13'(exp_cnt)) begin miscompares++; $display("FAIL rmw_wall: got in=%b err=%b cnt=%0d expected 1/1/%0d", maze_in, err, path_cnt, exp_cnt); end
    drive(1'b1, 1'b0, 10, 10, 1'b1);
    vectors++; if (maze_in !== 1'b0) begin miscompares++; $display("FAIL rmw_after: got %b expected 0", maze_in); end
  endtask

  task automatic test_random_ops();
    int r, c;
    logic oe, we;
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 7);
      c  = $urandom_range(0, 7);
      oe = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      drive(oe, we, r, c, 1'b1);
      vectors++;
      if (maze_in !== exp_in || path_cnt !== 13'(exp_cnt) || err !== exp_err) begin
        miscompares++;
        $display("FAIL random_op %0d (%0d,%0d oe=%b we=%b): got in=%b cnt=%0d err=%b expected %b/%0d/%b",
                 n, r, c, oe, we, maze_in, path_cnt, err, exp_in, exp_cnt, exp_err);
      end
    end
  endtask

  task automatic test_reset_midload();
    int r, c;
    for (int k = 0; k < 4096; k++) next_map[k] = 1'($urandom_range(0, 1));
    stream_map(2000);
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL midload_ready: got %b expected 1", load_ready); end
    #2;
    rst = 1'b1;
    #2;
    vectors++; if (loaded !== 1'b0 || load_ready !== 1'b0 || path_cnt !== 13'd0) begin miscompares++; $display("FAIL midload_reset: got loaded=%b ready=%b cnt=%0d expected 0/0/0", loaded, load_ready, path_cnt); end
    rst = 1'b0;
    exp_err = 1'b0;
    exp_in  = 1'b1;
    step();
    stream_map(-1);
    vectors++; if (loaded !== 1'b1 || path_cnt !== 13'd0) begin miscompares++; $display("FAIL reload: got loaded=%b cnt=%0d expected 1/0", loaded, path_cnt); end
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 63);
      c = $urandom_range(0, 63);
      drive(1'b1, 1'b0, r, c, 1'b1);
      vectors++; if (maze_in !== exp_in) begin miscompares++; $display("FAIL reload_read(%0d,%0d): got %b expected %b", r, c, maze_in, exp_in); end
    end
  endtask

`ifdef MAZE_STORE_CLEAR_EN
  task automatic test_clear();
    int mr[3], mc[3];
    int n;
    for (int m = 0; m < 3; m++) begin
      do begin
        mr[m] = $urandom_range(0, 63);
        mc[m] = $urandom_range(0, 63);
      end while (model_cell[mr[m] * 64 + mc[m]] != 0);
      drive(1'b0, 1'b1, mr[m], mc[m], 1'b1);
    end
    vectors++; if (path_cnt !== 13'(exp_cnt)) begin miscompares++; $display("FAIL clear_premark: got %0d expected %0d", path_cnt, exp_cnt); end
    drive(1'b1, 1'b0, mr[0], mc[0], 1'b1);
    clear_path = 1'b1;
    step();
    clear_path = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 5000) begin
      if (n == 100) maze_oe = 1'b1;
      step();
      if (n == 100) begin
        maze_oe = 1'b0;
        vectors++; if (maze_in !== 1'b1 || err !== 1'b1 || loaded !== 1'b0) begin miscompares++; $display("FAIL clear_oe: got in=%b err=%b loaded=%b expected 1/1/0", maze_in, err, loaded); end
      end
      n++;
    end
    vectors++; if (n !== 4096) begin miscompares++; $display("FAIL clear_time: got %0d cycles expected 4096", n); end
    for (int k = 0; k < 4096; k++) if (model_cell[k] == 2) model_cell[k] = 0;
    exp_cnt = 0;
    exp_err = 1'b1;
    vectors++; if (loaded !== 1'b1 || path_cnt !== 13'd0) begin miscompares++; $display("FAIL clear_done: got loaded=%b cnt=%0d expected 1/0", loaded, path_cnt); end
    for (int m = 0; m < 3; m++) begin
      drive(1'b1, 1'b0, mr[m], mc[m], 1'b1);
      vectors++; if (maze_in !== 1'b0) begin miscompares++; $display("FAIL clear_cell %0d: got %b expected 0", m, maze_in); end
    end
    for (int m = 0; m < 20; m++) begin
      int r, c;
      r = $urandom_range(0, 63);
      c = $urandom_range(0, 63);
      drive(1'b1, 1'b0, r, c, 1'b1);
      vectors++; if (maze_in !== exp_in) begin miscompares++; $display("FAIL clear_walls(%0d,%0d): got %b expected %b", r, c, maze_in, exp_in); end
    end
    drive(1'b0, 1'b1, mr[0], mc[0], 1'b1);
    vectors++; if (path_cnt !== 13'd1) begin miscompares++; $display("FAIL clear_remark: got %0d expected 1", path_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_mark();
    test_oe_we_same();
    test_random_ops();
    test_reset_midload();
`ifdef MAZE_STORE_CLEAR_EN
    test_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
